param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/param_updown_counter_if.sv | 23 ++
 rtl/param_updown_counter.sv | 55 +++++
 tb/tb_param_updown_counter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/param_updown_counter_if.sv
// Control and status bundle for the up/down counter.
// The master drives the count controls; the slave is the counter itself.
interface param_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             zero;

  modport master (
    output en, up_dn, load, load_val,
    input  cnt, tc, zero
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output cnt, tc, zero
  );
endinterface

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter, modulo MAX_VAL+1, with optional saturation,
// clamped synchronous load and a registered terminal-count pulse.
module param_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  param_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (!rst_n) begin
      cnt_d = '0;
    end else if (bus.load) begin
      cnt_d = (bus.load_val > MAX_CNT) ? MAX_CNT : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        // Boundary test uses >= so the wrap never steps through WIDTH overflow.
        if (cnt_q >= MAX_CNT) begin
          cnt_d = (SATURATE != 0) ? MAX_CNT : '0;
          tc_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d = (SATURATE != 0) ? '0 : MAX_CNT;
          tc_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    tc_q  <= tc_d;
  end

  assign bus.cnt  = cnt_q;
  assign bus.tc   = tc_q;
  assign bus.zero = (cnt_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: three counter configurations driven by directed vectors;
// expected results are queued at issue time and checked by a separate monitor.
module tb_param_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  param_updown_counter_if #(.WIDTH(4)) if_a ();
  param_updown_counter_if #(.WIDTH(4)) if_b ();
  param_updown_counter_if #(.WIDTH(4)) if_c ();

  // A: MAX_VAL=9 wrap, B: MAX_VAL=9 saturate, C: defaults (legacy down counter)
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_a (
    .clk(clk), .rst_n(rst_a), .bus(if_a)
  );
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u_b (
    .clk(clk), .rst_n(rst_b), .bus(if_b)
  );
  param_updown_counter u_c (
    .clk(clk), .rst_n(rst_c), .bus(if_c)
  );

  typedef struct {
    int         id;
    logic [3:0] cnt;
    logic       tc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Drive one DUT for one edge and queue the response expected after it.
  task automatic step(input int id, input logic r, input logic e, input logic u,
                      input logic l, input logic [3:0] lv,
                      input logic [3:0] exp_cnt, input logic exp_tc,
                      input string name);
    exp_t x;
    @(negedge clk);
    #1;
    case (id)
      0: begin rst_a = r; if_a.en = e; if_a.up_dn = u; if_a.load = l; if_a.load_val = lv; end
      1: begin rst_b = r; if_b.en = e; if_b.up_dn = u; if_b.load = l; if_b.load_val = lv; end
      default: begin rst_c = r; if_c.en = e; if_c.up_dn = u; if_c.load = l; if_c.load_val = lv; end
    endcase
    x.id = id; x.cnt = exp_cnt; x.tc = exp_tc; x.name = name;
    sb.push_back(x);
  endtask

  // Monitor: every falling edge, compare each queued expectation with the DUT.
  initial begin
    exp_t       x;
    logic [3:0] a_cnt;
    logic       a_tc, a_zero, e_zero;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        x = sb.pop_front();
        case (x.id)
          0: begin a_cnt = if_a.cnt; a_tc = if_a.tc; a_zero = if_a.zero; end
          1: begin a_cnt = if_b.cnt; a_tc = if_b.tc; a_zero = if_b.zero; end
          default: begin a_cnt = if_c.cnt; a_tc = if_c.tc; a_zero = if_c.zero; end
        endcase
        e_zero = (x.cnt == 4'd0);
        checks++;
        if (a_cnt !== x.cnt || a_tc !== x.tc || a_zero !== e_zero) begin
          errors++;
          $display("FAIL %s dut%0d: got cnt=%0d tc=%b zero=%b, expected cnt=%0d tc=%b zero=%b",
                   x.name, x.id, a_cnt, a_tc, a_zero, x.cnt, x.tc, e_zero);
        end else begin
          $display("ok   %s dut%0d cnt=%0d tc=%b zero=%b", x.name, x.id, a_cnt, a_tc, a_zero);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m;
    logic       r;
    logic       mtc;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    if_a.en = 0; if_a.up_dn = 0; if_a.load = 0; if_a.load_val = '0;
    if_b.en = 0; if_b.up_dn = 0; if_b.load = 0; if_b.load_val = '0;
    if_c.en = 0; if_c.up_dn = 0; if_c.load = 0; if_c.load_val = '0;

    // ---------------- DUT A: MAX_VAL=9, wrap ----------------
    step(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, "reset_a");
    step(0, 1, 0, 0, 1, 4'd5, 4'd5, 0, "load5");
    step(0, 0, 1, 1, 1, 4'd7, 4'd0, 0, "rst_over_load");
    // Down from reset: wrap to 9 with tc, then 8..0, then wrap again
    step(0, 1, 1, 0, 0, 4'd0, 4'd9, 1, "down_wrap");
    for (int v = 8; v >= 0; v--)
      step(0, 1, 1, 0, 0, 4'd0, 4'(v), 0, "down_seq");
    step(0, 1, 1, 0, 0, 4'd0, 4'd9, 1, "down_wrap2");
    // Up from 0 for 10 edges
    step(0, 0, 1, 1, 0, 4'd0, 4'd0, 0, "reset_mid");
    for (int v = 1; v <= 9; v++)
      step(0, 1, 1, 1, 0, 4'd0, 4'(v), 0, "up_seq");
    step(0, 1, 1, 1, 0, 4'd0, 4'd0, 1, "up_wrap");
    // up_dn toggling from 4
    step(0, 1, 0, 0, 1, 4'd4, 4'd4, 0, "load4");
    step(0, 1, 1, 1, 0, 4'd0, 4'd5, 0, "toggle_up1");
    step(0, 1, 1, 0, 0, 4'd0, 4'd4, 0, "toggle_dn1");
    step(0, 1, 1, 1, 0, 4'd0, 4'd5, 0, "toggle_up2");
    step(0, 1, 1, 0, 0, 4'd0, 4'd4, 0, "toggle_dn2");
    step(0, 1, 0, 1, 0, 4'd0, 4'd4, 0, "hold1");
    step(0, 1, 0, 0, 0, 4'd0, 4'd4, 0, "hold2");
    // Load clamp, and load overriding a boundary count
    step(0, 1, 0, 0, 1, 4'd12, 4'd9, 0, "load_clamp_a");
    step(0, 1, 1, 1, 1, 4'd3, 4'd3, 0, "load_over_en");
    step(0, 1, 1, 1, 1, 4'd9, 4'd9, 0, "load_max");
    step(0, 1, 1, 1, 0, 4'd0, 4'd0, 1, "up_wrap_load");
    step(0, 1, 0, 0, 1, 4'd15, 4'd9, 0, "load_clamp15");

    // ---------------- DUT B: MAX_VAL=9, saturate ----------------
    step(1, 0, 0, 0, 0, 4'd0, 4'd0, 0, "reset_b");
    step(1, 1, 1, 0, 0, 4'd0, 4'd0, 1, "sat_low1");
    step(1, 1, 1, 0, 0, 4'd0, 4'd0, 1, "sat_low2");
    step(1, 1, 0, 1, 1, 4'd12, 4'd9, 0, "load_clamp_b");
    for (int k = 0; k < 3; k++)
      step(1, 1, 1, 1, 0, 4'd0, 4'd9, 1, "sat_high");
    step(1, 1, 1, 0, 0, 4'd0, 4'd8, 0, "sat_leave");
    step(1, 1, 0, 0, 0, 4'd0, 4'd8, 0, "sat_hold");

    // ---------------- DUT C: defaults, random reset ----------------
    step(2, 0, 1, 0, 0, 4'd0, 4'd0, 0, "reset_c");
    m = 4'd0;
    for (int k = 0; k < 100; k++) begin
      r = ($urandom_range(0, 9) != 0);
      if (!r) begin
        m = 4'd0; mtc = 1'b0;
      end else if (m == 4'd0) begin
        m = 4'd15; mtc = 1'b1;
      end else begin
        m = m - 4'd1; mtc = 1'b0;
      end
      step(2, r, 1, 0, 0, 4'd0, m, mtc, "legacy_rand");
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb.size() > 0; k++)
      @(negedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
